// File: rtl/id_stage_hazard_p.sv
// MIPS decode stage: regfile, decode, sign-extend, ID/EX register with load-use stall and flush.
// Optional WB_BYPASS_EN: same-cycle writeback data forwarded onto the read ports.
module id_stage_hazard_p #(
    parameter int DW   = 32,
    parameter int NREG = 32,
    localparam int AW  = $clog2(NREG)
) (
    input  logic          CLK,
    input  logic          RESET,
    input  logic [DW-1:0] I_ID_PC,
    input  logic [31:0]   I_ID_Instr,
    input  logic          I_ID_VALID,
    input  logic          I_ID_FLUSH,
    input  logic          I_WB_REGWR,
    input  logic [AW-1:0] I_WB_ADDR,
    input  logic [DW-1:0] I_WB_DATA,
    output logic          O_ID_STALL,
    output logic          O_ID_VALID,
    output logic [14:0]   O_ID_ControlReg,
    output logic [DW-1:0] O_ID_PC,
    output logic [DW-1:0] O_ID_ReadData1,
    output logic [DW-1:0] O_ID_ReadData2,
    output logic [DW-1:0] O_ID_SignExt,
    output logic [AW-1:0] O_ID_RS,
    output logic [AW-1:0] O_ID_RT,
    output logic [AW-1:0] O_ID_RD
);

    logic [DW-1:0] regs [NREG];

    logic [5:0]    op;
    logic [5:0]    funct;
    logic [AW-1:0] id_rs;
    logic [AW-1:0] id_rt;
    logic [AW-1:0] id_rd;
    logic [DW-1:0] id_sext;
    logic [DW-1:0] rd1;
    logic [DW-1:0] rd2;
    logic [14:0]   dec_ctrl;
    logic          unused_shamt;

    assign op           = I_ID_Instr[31:26];
    assign funct        = I_ID_Instr[5:0];
    assign id_rs        = AW'(I_ID_Instr[25:21]);
    assign id_rt        = AW'(I_ID_Instr[20:16]);
    assign id_rd        = AW'(I_ID_Instr[15:11]);
    assign id_sext      = {{(DW-16){I_ID_Instr[15]}}, I_ID_Instr[15:0]};
    assign unused_shamt = ^I_ID_Instr[10:6];

    always_ff @(posedge CLK) begin
        if (RESET) begin
            for (int i = 0; i < NREG; i++)
                regs[i] <= '0;
        end else if (I_WB_REGWR && I_WB_ADDR != '0) begin
            regs[I_WB_ADDR] <= I_WB_DATA;
        end
    end

    // r0 is never written, but the read mux still forces zero so bypass can't leak into it
    always_comb begin
        rd1 = regs[id_rs];
        rd2 = regs[id_rt];
`ifdef WB_BYPASS_EN
        if (I_WB_REGWR && I_WB_ADDR == id_rs)
            rd1 = I_WB_DATA;
        if (I_WB_REGWR && I_WB_ADDR == id_rt)
            rd2 = I_WB_DATA;
`endif
        if (id_rs == '0)
            rd1 = '0;
        if (id_rt == '0)
            rd2 = '0;
    end

    // {ALUF[5:0], RegDst, ALUOp[1:0], ALUSrc, Branch, MemRead, MemWrite, RegWrite, MemtoReg}
    always_comb begin
        dec_ctrl = '0;
        unique case (1'b1)
            op == 6'h00: dec_ctrl = {funct, 1'b1, 2'b10, 6'b000010};
            op == 6'h23: dec_ctrl = {6'h00, 1'b0, 2'b00, 6'b101011};
            op == 6'h2B: dec_ctrl = {6'h00, 1'b0, 2'b00, 6'b100100};
            op == 6'h04: dec_ctrl = {6'h00, 1'b0, 2'b01, 6'b010000};
            op == 6'h08: dec_ctrl = {6'h00, 1'b0, 2'b00, 6'b100010};
            default:     dec_ctrl = '0;
        endcase
    end

    logic load_in_ex;
    logic rt_clash;

    assign load_in_ex = O_ID_VALID & O_ID_ControlReg[3];
    assign rt_clash   = (O_ID_RT != '0) &
                        ((O_ID_RT == id_rs) | (O_ID_RT == id_rt));
    assign O_ID_STALL = load_in_ex & I_ID_VALID & ~I_ID_FLUSH & rt_clash;

    // Bubbles zero only valid/control; data fields just hold
    always_ff @(posedge CLK) begin
        if (RESET) begin
            O_ID_VALID      <= 1'b0;
            O_ID_ControlReg <= '0;
            O_ID_PC         <= '0;
            O_ID_ReadData1  <= '0;
            O_ID_ReadData2  <= '0;
            O_ID_SignExt    <= '0;
            O_ID_RS         <= '0;
            O_ID_RT         <= '0;
            O_ID_RD         <= '0;
        end else if (I_ID_FLUSH || O_ID_STALL) begin
            O_ID_VALID      <= 1'b0;
            O_ID_ControlReg <= '0;
        end else begin
            O_ID_VALID      <= I_ID_VALID;
            O_ID_ControlReg <= I_ID_VALID ? dec_ctrl : '0;
            O_ID_PC         <= I_ID_PC;
            O_ID_ReadData1  <= rd1;
            O_ID_ReadData2  <= rd2;
            O_ID_SignExt    <= id_sext;
            O_ID_RS         <= id_rs;
            O_ID_RT         <= id_rt;
            O_ID_RD         <= id_rd;
        end
    end

endmodule

// File: tb/tb_id_stage_hazard_p.sv
// Directed bench for id_stage_hazard_p: decode, regfile, load-use stall, flush.
// Expected read-during-write value depends on WB_BYPASS_EN.
module tb_id_stage_hazard_p;

    localparam int DW = 32;
    localparam int AW = 5;

    logic          CLK;
    logic          RESET;
    logic [DW-1:0] I_ID_PC;
    logic [31:0]   I_ID_Instr;
    logic          I_ID_VALID;
    logic          I_ID_FLUSH;
    logic          I_WB_REGWR;
    logic [AW-1:0] I_WB_ADDR;
    logic [DW-1:0] I_WB_DATA;
    logic          O_ID_STALL;
    logic          O_ID_VALID;
    logic [14:0]   O_ID_ControlReg;
    logic [DW-1:0] O_ID_PC;
    logic [DW-1:0] O_ID_ReadData1;
    logic [DW-1:0] O_ID_ReadData2;
    logic [DW-1:0] O_ID_SignExt;
    logic [AW-1:0] O_ID_RS;
    logic [AW-1:0] O_ID_RT;
    logic [AW-1:0] O_ID_RD;

    int nvec = 0;
    int nerr = 0;

    localparam logic [14:0] C_ADD  = 15'h4182;
    localparam logic [14:0] C_LW   = 15'h002B;
    localparam logic [14:0] C_SW   = 15'h0024;
    localparam logic [14:0] C_BEQ  = 15'h0050;
    localparam logic [14:0] C_ADDI = 15'h0022;

    id_stage_hazard_p #(.DW(DW), .NREG(32)) dut (
        .CLK(CLK), .RESET(RESET),
        .I_ID_PC(I_ID_PC), .I_ID_Instr(I_ID_Instr),
        .I_ID_VALID(I_ID_VALID), .I_ID_FLUSH(I_ID_FLUSH),
        .I_WB_REGWR(I_WB_REGWR), .I_WB_ADDR(I_WB_ADDR),
        .I_WB_DATA(I_WB_DATA),
        .O_ID_STALL(O_ID_STALL), .O_ID_VALID(O_ID_VALID),
        .O_ID_ControlReg(O_ID_ControlReg), .O_ID_PC(O_ID_PC),
        .O_ID_ReadData1(O_ID_ReadData1), .O_ID_ReadData2(O_ID_ReadData2),
        .O_ID_SignExt(O_ID_SignExt),
        .O_ID_RS(O_ID_RS), .O_ID_RT(O_ID_RT), .O_ID_RD(O_ID_RD)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    function automatic logic [31:0] rtype(input logic [4:0] rs, input logic [4:0] rt,
                                          input logic [4:0] rd, input logic [5:0] fn);
        return {6'h00, rs, rt, rd, 5'h00, fn};
    endfunction

    function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic drive(input logic [31:0] pc, input logic [31:0] ins, input logic v);
        I_ID_PC    = pc;
        I_ID_Instr = ins;
        I_ID_VALID = v;
    endtask

    task automatic test_reset();
        RESET = 1'b1;
        drive(32'h40, rtype(5'd1, 5'd2, 5'd3, 6'h20), 1'b1);
        tick();
        tick();
        nvec++; if (O_ID_VALID !== 1'b0) begin nerr++; $display("FAIL reset_valid got %0b want 0", O_ID_VALID); end
        nvec++; if (O_ID_ControlReg !== 15'h0) begin nerr++; $display("FAIL reset_ctrl got %h want 0", O_ID_ControlReg); end
        nvec++; if ({O_ID_PC, O_ID_ReadData1, O_ID_ReadData2, O_ID_SignExt} !== '0) begin nerr++; $display("FAIL reset_data got %h %h %h %h want 0", O_ID_PC, O_ID_ReadData1, O_ID_ReadData2, O_ID_SignExt); end
        nvec++; if ({O_ID_RS, O_ID_RT, O_ID_RD} !== '0) begin nerr++; $display("FAIL reset_regs got %h %h %h want 0", O_ID_RS, O_ID_RT, O_ID_RD); end
        nvec++; if (O_ID_STALL !== 1'b0) begin nerr++; $display("FAIL reset_stall got %0b want 0", O_ID_STALL); end
        RESET = 1'b0;
        drive(32'h44, rtype(5'd5, 5'd31, 5'd3, 6'h20), 1'b1);
        tick();
        nvec++; if (O_ID_ReadData1 !== 32'h0 || O_ID_ReadData2 !== 32'h0) begin nerr++; $display("FAIL reset_rf got %h %h want 0 0", O_ID_ReadData1, O_ID_ReadData2); end
    endtask

    task automatic test_rtype();
        drive(32'h0, 32'h0, 1'b0);
        I_WB_REGWR = 1'b1; I_WB_ADDR = 5'd5; I_WB_DATA = 32'h1234;
        tick();
        I_WB_REGWR = 1'b0;
        drive(32'h80, rtype(5'd5, 5'd0, 5'd3, 6'h20), 1'b1);
        tick();
        nvec++; if (O_ID_ReadData1 !== 32'h1234) begin nerr++; $display("FAIL add_rd1 got %h want 1234", O_ID_ReadData1); end
        nvec++; if (O_ID_ReadData2 !== 32'h0) begin nerr++; $display("FAIL add_rd2 got %h want 0", O_ID_ReadData2); end
        nvec++; if (O_ID_ControlReg !== C_ADD) begin nerr++; $display("FAIL add_ctrl got %h want %h", O_ID_ControlReg, C_ADD); end
        nvec++; if (O_ID_VALID !== 1'b1) begin nerr++; $display("FAIL add_valid got %0b want 1", O_ID_VALID); end
        nvec++; if (O_ID_PC !== 32'h80 || O_ID_RS !== 5'd5 || O_ID_RT !== 5'd0 || O_ID_RD !== 5'd3) begin nerr++; $display("FAIL add_fields got pc=%h rs=%0d rt=%0d rd=%0d want 80 5 0 3", O_ID_PC, O_ID_RS, O_ID_RT, O_ID_RD); end
    endtask

    task automatic test_load_use();
        drive(32'h100, itype(6'h23, 5'd1, 5'd2, 16'hFFFC), 1'b1);
        #1;
        nvec++; if (O_ID_STALL !== 1'b0) begin nerr++; $display("FAIL lu_nostall_pre got %0b want 0", O_ID_STALL); end
        tick();
        nvec++; if (O_ID_SignExt !== 32'hFFFFFFFC) begin nerr++; $display("FAIL lu_sext got %h want fffffffc", O_ID_SignExt); end
        nvec++; if (O_ID_ControlReg !== C_LW || O_ID_RT !== 5'd2) begin nerr++; $display("FAIL lu_lw got ctrl=%h rt=%0d want %h 2", O_ID_ControlReg, O_ID_RT, C_LW); end
        drive(32'h104, rtype(5'd2, 5'd2, 5'd4, 6'h20), 1'b1);
        #1;
        nvec++; if (O_ID_STALL !== 1'b1) begin nerr++; $display("FAIL lu_stall got %0b want 1", O_ID_STALL); end
        tick();
        nvec++; if (O_ID_VALID !== 1'b0 || O_ID_ControlReg !== 15'h0) begin nerr++; $display("FAIL lu_bubble got v=%0b ctrl=%h want 0 0", O_ID_VALID, O_ID_ControlReg); end
        nvec++; if (O_ID_STALL !== 1'b0) begin nerr++; $display("FAIL lu_stall_once got %0b want 0", O_ID_STALL); end
        tick();
        nvec++; if (O_ID_VALID !== 1'b1 || O_ID_ControlReg !== C_ADD || O_ID_PC !== 32'h104 || O_ID_RD !== 5'd4) begin nerr++; $display("FAIL lu_add got v=%0b ctrl=%h pc=%h rd=%0d want 1 %h 104 4", O_ID_VALID, O_ID_ControlReg, O_ID_PC, O_ID_RD, C_ADD); end
    endtask

    task automatic test_r0_flush();
        drive(32'h200, itype(6'h23, 5'd1, 5'd0, 16'h0004), 1'b1);
        tick();
        drive(32'h204, rtype(5'd0, 5'd0, 5'd4, 6'h20), 1'b1);
        #1;
        nvec++; if (O_ID_STALL !== 1'b0) begin nerr++; $display("FAIL r0_nostall got %0b want 0", O_ID_STALL); end
        tick();
        drive(32'h208, itype(6'h23, 5'd1, 5'd2, 16'h0000), 1'b1);
        tick();
        drive(32'h20C, rtype(5'd3, 5'd2, 5'd4, 6'h20), 1'b1);
        #1;
        nvec++; if (O_ID_STALL !== 1'b1) begin nerr++; $display("FAIL rt_stall got %0b want 1", O_ID_STALL); end
        I_ID_VALID = 1'b0;
        #1;
        nvec++; if (O_ID_STALL !== 1'b0) begin nerr++; $display("FAIL invalid_nostall got %0b want 0", O_ID_STALL); end
        I_ID_VALID = 1'b1;
        I_ID_FLUSH = 1'b1;
        #1;
        nvec++; if (O_ID_STALL !== 1'b0) begin nerr++; $display("FAIL flush_nostall got %0b want 0", O_ID_STALL); end
        tick();
        nvec++; if (O_ID_VALID !== 1'b0 || O_ID_ControlReg !== 15'h0) begin nerr++; $display("FAIL flush_bubble got v=%0b ctrl=%h want 0 0", O_ID_VALID, O_ID_ControlReg); end
        I_ID_FLUSH = 1'b0;
    endtask

    task automatic test_wb_bypass();
        logic [31:0] exp;
        drive(32'h300, 32'h0, 1'b0);
        I_WB_REGWR = 1'b1; I_WB_ADDR = 5'd7; I_WB_DATA = 32'h11;
        tick();
        I_WB_DATA = 32'hA5;
        drive(32'h304, rtype(5'd7, 5'd0, 5'd1, 6'h20), 1'b1);
        tick();
`ifdef WB_BYPASS_EN
        exp = 32'hA5;
`else
        exp = 32'h11;
`endif
        nvec++; if (O_ID_ReadData1 !== exp) begin nerr++; $display("FAIL wb_same got %h want %h", O_ID_ReadData1, exp); end
        I_WB_REGWR = 1'b0;
        tick();
        nvec++; if (O_ID_ReadData1 !== 32'hA5) begin nerr++; $display("FAIL wb_next got %h want a5", O_ID_ReadData1); end
        I_WB_REGWR = 1'b1; I_WB_ADDR = 5'd0; I_WB_DATA = 32'hFF;
        drive(32'h308, rtype(5'd0, 5'd7, 5'd1, 6'h20), 1'b1);
        tick();
        nvec++; if (O_ID_ReadData1 !== 32'h0 || O_ID_ReadData2 !== 32'hA5) begin nerr++; $display("FAIL wb_r0_same got %h %h want 0 a5", O_ID_ReadData1, O_ID_ReadData2); end
        I_WB_REGWR = 1'b0;
        tick();
        nvec++; if (O_ID_ReadData1 !== 32'h0) begin nerr++; $display("FAIL wb_r0_next got %h want 0", O_ID_ReadData1); end
    endtask

    task automatic test_opcodes();
        drive(32'h400, itype(6'h3F, 5'd1, 5'd2, 16'h1234), 1'b1);
        tick();
        nvec++; if (O_ID_ControlReg !== 15'h0 || O_ID_VALID !== 1'b1) begin nerr++; $display("FAIL op3f_v1 got ctrl=%h v=%0b want 0 1", O_ID_ControlReg, O_ID_VALID); end
        I_ID_VALID = 1'b0;
        tick();
        nvec++; if (O_ID_ControlReg !== 15'h0 || O_ID_VALID !== 1'b0) begin nerr++; $display("FAIL op3f_v0 got ctrl=%h v=%0b want 0 0", O_ID_ControlReg, O_ID_VALID); end
        drive(32'h404, itype(6'h23, 5'd1, 5'd9, 16'h0), 1'b0);
        tick();
        nvec++; if (O_ID_ControlReg !== 15'h0 || O_ID_VALID !== 1'b0) begin nerr++; $display("FAIL lw_invalid got ctrl=%h v=%0b want 0 0", O_ID_ControlReg, O_ID_VALID); end
        drive(32'h408, itype(6'h2B, 5'd1, 5'd9, 16'h0008), 1'b1);
        tick();
        nvec++; if (O_ID_ControlReg !== C_SW) begin nerr++; $display("FAIL sw_ctrl got %h want %h", O_ID_ControlReg, C_SW); end
        drive(32'h40C, itype(6'h04, 5'd1, 5'd9, 16'h8000), 1'b1);
        tick();
        nvec++; if (O_ID_ControlReg !== C_BEQ || O_ID_SignExt !== 32'hFFFF8000) begin nerr++; $display("FAIL beq got ctrl=%h sext=%h want %h ffff8000", O_ID_ControlReg, O_ID_SignExt, C_BEQ); end
        drive(32'h410, itype(6'h08, 5'd1, 5'd9, 16'h7FFF), 1'b1);
        tick();
        nvec++; if (O_ID_ControlReg !== C_ADDI || O_ID_SignExt !== 32'h00007FFF) begin nerr++; $display("FAIL addi got ctrl=%h sext=%h want %h 00007fff", O_ID_ControlReg, O_ID_SignExt, C_ADDI); end
        drive(32'h414, rtype(5'd1, 5'd2, 5'd3, 6'h22), 1'b1);
        tick();
        nvec++; if (O_ID_ControlReg !== 15'h4582) begin nerr++; $display("FAIL sub_aluf got %h want 4582", O_ID_ControlReg); end
    endtask

    task automatic test_reset_mid_stall();
        drive(32'h500, itype(6'h23, 5'd1, 5'd6, 16'h0), 1'b1);
        tick();
        drive(32'h504, rtype(5'd6, 5'd1, 5'd4, 6'h20), 1'b1);
        #1;
        nvec++; if (O_ID_STALL !== 1'b1) begin nerr++; $display("FAIL rms_stall got %0b want 1", O_ID_STALL); end
        RESET = 1'b1;
        tick();
        nvec++; if (O_ID_STALL !== 1'b0 || O_ID_VALID !== 1'b0 || O_ID_ControlReg !== 15'h0) begin nerr++; $display("FAIL rms_after got s=%0b v=%0b ctrl=%h want 0 0 0", O_ID_STALL, O_ID_VALID, O_ID_ControlReg); end
        RESET = 1'b0;
        tick();
        nvec++; if (O_ID_VALID !== 1'b1 || O_ID_ControlReg !== C_ADD || O_ID_PC !== 32'h504) begin nerr++; $display("FAIL rms_resume got v=%0b ctrl=%h pc=%h want 1 %h 504", O_ID_VALID, O_ID_ControlReg, O_ID_PC, C_ADD); end
    endtask

    initial begin
        RESET      = 1'b1;
        I_ID_FLUSH = 1'b0;
        I_WB_REGWR = 1'b0;
        I_WB_ADDR  = '0;
        I_WB_DATA  = '0;
        drive(32'h0, 32'h0, 1'b0);
        test_reset();
        test_rtype();
        test_load_use();
        test_r0_flush();
        test_wb_bypass();
        test_opcodes();
        test_reset_mid_stall();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
